// File: rtl/instruction_fetch.sv
// Fetch stage: turns a program counter into one word-aligned memory read and hands
// {pc, instruction, fault} to decode; a flush abandons whatever fetch is in flight.
module instruction_fetch #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  pc,
   input  logic                   pc_valid,
   input  logic                   flush,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [ADDR_WIDTH-1:0]  mem_req_addr,
   input  logic                   mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]  mem_rsp_data,
   input  logic                   mem_rsp_error,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   output logic [DATA_WIDTH-1:0]  instr_data,
   output logic [1:0]             instr_fault,
   output logic [COUNT_WIDTH-1:0] fetch_count
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_OUT   = 3'd4;

   localparam logic [1:0] FAULT_NONE     = 2'd0;
   localparam logic [1:0] FAULT_MISALIGN = 2'd1;
   localparam logic [1:0] FAULT_BUS      = 2'd2;

   // A bus error never forwards the (meaningless) read data to decode.
   function automatic logic [DATA_WIDTH-1:0] rsp_data_sel(input logic                  err,
                                                          input logic [DATA_WIDTH-1:0] data);
      return err ? '0 : data;
   endfunction

   function automatic logic [1:0] rsp_fault_sel(input logic err);
      return err ? FAULT_BUS : FAULT_NONE;
   endfunction

   logic [2:0]             state_q,         state_d;
   logic                   drop_q,          drop_d;
   logic                   mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_WIDTH-1:0]  mem_req_addr_q,  mem_req_addr_d;
   logic                   instr_valid_q,   instr_valid_d;
   logic [ADDR_WIDTH-1:0]  instr_pc_q,      instr_pc_d;
   logic [DATA_WIDTH-1:0]  instr_data_q,    instr_data_d;
   logic [1:0]             instr_fault_q,   instr_fault_d;
   logic [COUNT_WIDTH-1:0] fetch_count_q,   fetch_count_d;

   always_comb begin
      state_d        = state_q;
      drop_d         = drop_q;
      mem_req_addr_d = mem_req_addr_q;
      instr_pc_d     = instr_pc_q;
      instr_data_d   = instr_data_q;
      instr_fault_d  = instr_fault_q;
      fetch_count_d  = fetch_count_q;

      case (state_q)
         ST_IDLE: begin
            drop_d = 1'b0;
            if (pc_valid && !flush) begin
               instr_pc_d = pc;
               if (pc[1:0] != 2'b00) begin
                  instr_data_d  = '0;
                  instr_fault_d = FAULT_MISALIGN;
                  state_d       = ST_OUT;
               end else begin
                  mem_req_addr_d = pc;
                  state_d        = ST_REQ;
               end
            end
         end

         // The request is never withdrawn; a flush only marks its response for discard.
         ST_REQ: begin
            if (mem_req_ready) begin
               state_d = (flush || drop_q) ? ST_DRAIN : ST_WAIT;
               drop_d  = 1'b0;
            end else if (flush) begin
               drop_d = 1'b1;
            end
         end

         ST_WAIT: begin
            if (mem_rsp_valid) begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else begin
                  instr_data_d  = rsp_data_sel(mem_rsp_error, mem_rsp_data);
                  instr_fault_d = rsp_fault_sel(mem_rsp_error);
                  state_d       = ST_OUT;
               end
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            if (mem_rsp_valid) begin
               state_d = ST_IDLE;
            end
         end

         // Flush takes priority over a same-cycle accept, so the instruction is not counted.
         ST_OUT: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (instr_ready) begin
               fetch_count_d = fetch_count_q + COUNT_WIDTH'(1);
               state_d       = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            drop_d  = 1'b0;
         end
      endcase

      mem_req_valid_d = (state_d == ST_REQ);
      instr_valid_d   = (state_d == ST_OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         drop_q          <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= '0;
         instr_valid_q   <= 1'b0;
         instr_pc_q      <= '0;
         instr_data_q    <= '0;
         instr_fault_q   <= FAULT_NONE;
         fetch_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         drop_q          <= drop_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_addr_q  <= mem_req_addr_d;
         instr_valid_q   <= instr_valid_d;
         instr_pc_q      <= instr_pc_d;
         instr_data_q    <= instr_data_d;
         instr_fault_q   <= instr_fault_d;
         fetch_count_q   <= fetch_count_d;
      end
   end

   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr  = mem_req_addr_q;
   assign instr_valid   = instr_valid_q;
   assign instr_pc      = instr_pc_q;
   assign instr_data    = instr_data_q;
   assign instr_fault   = instr_fault_q;
   assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus queues expected decode packets,
// a monitor pops and compares each presented instruction and checks it holds steady.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc = '0;
   logic        pc_valid = 1'b0;
   logic        flush = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        mem_rsp_error = 1'b0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_pc;
   logic [31:0] instr_data;
   logic [1:0]  instr_fault;
   logic [31:0] fetch_count;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic [1:0]  fault;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   instruction_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_error(mem_rsp_error),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc),
      .instr_data(instr_data), .instr_fault(instr_fault), .fetch_count(fetch_count)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_instr(input logic [31:0] p, input logic [31:0] d, input logic [1:0] f);
      exp_t e;
      e.pc = p; e.data = d; e.fault = f;
      sb.push_back(e);
   endtask

   // Aligned fetch with immediate ready and a one-cycle memory response.
   task automatic fetch_ok(input logic [31:0] p, input logic [31:0] d);
      expect_instr(p, d, 2'd0);
      pc = p; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      chk("req_valid", 64'(mem_req_valid), 64'(1));
      chk("req_addr", 64'(mem_req_addr), 64'(p));
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("req_drop_after_accept", 64'(mem_req_valid), 64'(0));
      mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_error = 1'b0;
      tick();
      mem_rsp_valid = 1'b0;
      chk("instr_valid_latency", 64'(instr_valid), 64'(1));
   endtask

   // Monitor: every rising instr_valid must match the head of the scoreboard,
   // and the packet must not change while it is being presented.
   initial begin
      logic        shown;
      exp_t        held;
      exp_t        e;
      shown = 1'b0;
      held  = '0;
      forever begin
         @(posedge clk);
         #2;
         if (instr_valid && !shown) begin
            shown = 1'b1;
            held  = {instr_pc, instr_data, instr_fault};
            if (sb.size() == 0) begin
               chk("unexpected_instr_pc", 64'(instr_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("sb_pc", 64'(instr_pc), 64'(e.pc));
               chk("sb_data", 64'(instr_data), 64'(e.data));
               chk("sb_fault", 64'(instr_fault), 64'(e.fault));
            end
         end else if (instr_valid && shown) begin
            chk("hold_pc", 64'(instr_pc), 64'(held.pc));
            chk("hold_data", 64'(instr_data), 64'(held.data));
            chk("hold_fault", 64'(instr_fault), 64'(held.fault));
         end else begin
            shown = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1;
      chk("rst_instr_valid", 64'(instr_valid), 64'(0));
      chk("rst_req_valid", 64'(mem_req_valid), 64'(0));
      chk("rst_count", 64'(fetch_count), 64'(0));
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // 1: basic aligned fetch, count to 1
      fetch_ok(32'h100, 32'h0050_0093);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t1_valid_low", 64'(instr_valid), 64'(0));
      chk("t1_count", 64'(fetch_count), 64'(1));

      // 2: misaligned pc goes straight to OUT, no memory request
      expect_instr(32'h102, 32'h0, 2'd1);
      pc = 32'h102; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      chk("t2_no_req", 64'(mem_req_valid), 64'(0));
      chk("t2_valid", 64'(instr_valid), 64'(1));
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t2_no_req_after", 64'(mem_req_valid), 64'(0));
      chk("t2_count", 64'(fetch_count), 64'(2));

      // 3: request held unaccepted 5 cycles, flush in cycle 2, response discarded
      pc = 32'h300; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         chk("t3_req_held", 64'(mem_req_valid), 64'(1));
         chk("t3_addr_stable", 64'(mem_req_addr), 64'(32'h300));
         flush = (i == 2);
         tick();
      end
      chk("t3_req_still", 64'(mem_req_valid), 64'(1));
      chk("t3_addr_final", 64'(mem_req_addr), 64'(32'h300));
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("t3_req_accepted", 64'(mem_req_valid), 64'(0));
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
      tick();
      mem_rsp_valid = 1'b0;
      chk("t3_no_instr", 64'(instr_valid), 64'(0));
      tick();
      chk("t3_no_instr_late", 64'(instr_valid), 64'(0));
      chk("t3_count", 64'(fetch_count), 64'(2));

      // 4: bus error, decode stalls 3 cycles, then counts once
      expect_instr(32'h200, 32'h0, 2'd2);
      pc = 32'h200; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_error = 1'b1; mem_rsp_data = 32'h1234_5678;
      tick();
      mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_valid_held", 64'(instr_valid), 64'(1));
         tick();
      end
      chk("t4_count_stalled", 64'(fetch_count), 64'(2));
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t4_count", 64'(fetch_count), 64'(3));
      chk("t4_valid_low", 64'(instr_valid), 64'(0));
      tick();
      chk("t4_count_once", 64'(fetch_count), 64'(3));

      // 5: flush and instr_ready together in OUT
      fetch_ok(32'h400, 32'h00A0_0113);
      flush = 1'b1; instr_ready = 1'b1;
      tick();
      flush = 1'b0; instr_ready = 1'b0;
      chk("t5_valid_low", 64'(instr_valid), 64'(0));
      chk("t5_count", 64'(fetch_count), 64'(3));

      // 6: reset during WAIT, stale response ignored, then a clean fetch
      pc = 32'h500; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(instr_valid), 64'(0));
      chk("t6_rst_req", 64'(mem_req_valid), 64'(0));
      chk("t6_rst_addr", 64'(mem_req_addr), 64'(0));
      chk("t6_rst_pc", 64'(instr_pc), 64'(0));
      chk("t6_rst_data", 64'(instr_data), 64'(0));
      chk("t6_rst_fault", 64'(instr_fault), 64'(0));
      chk("t6_rst_count", 64'(fetch_count), 64'(0));
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
      tick();
      rst_n = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      chk("t6_stale_ignored", 64'(instr_valid), 64'(0));
      chk("t6_idle_no_req", 64'(mem_req_valid), 64'(0));
      fetch_ok(32'h0, 32'h0000_0013);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t6_count", 64'(fetch_count), 64'(1));

      tick(); tick();
      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
